// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: STAGES-deep carry-lookahead add/sub with valid/ready; PADD_SAT_EN enables signed saturation
module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int NG    = CHUNK / 4;

    function automatic logic [CHUNK:0] cla(input logic [CHUNK-1:0] x, input logic [CHUNK-1:0] y, input logic cin);
        logic [NG-1:0]    g, p;
        logic [NG:0]      gc;
        logic [CHUNK-1:0] s;
        logic             gg, pp, t, c, bc;
        for (int j = 0; j < NG; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg = (x[4*j+i] & y[4*j+i]) | ((x[4*j+i] ^ y[4*j+i]) & gg);
                pp = pp & (x[4*j+i] ^ y[4*j+i]);
            end
            g[j] = gg;
            p[j] = pp;
        end
        for (int j = 0; j <= NG; j++) begin
            c = cin;
            for (int m = 0; m < j; m++) c = c & p[m];
            for (int i = 0; i < j; i++) begin
                t = g[i];
                for (int m = i + 1; m < j; m++) t = t & p[m];
                c = c | t;
            end
            gc[j] = c;
        end
        for (int j = 0; j < NG; j++) begin
            bc = gc[j];
            for (int i = 0; i < 4; i++) begin
                s[4*j+i] = x[4*j+i] ^ y[4*j+i] ^ bc;
                bc = (x[4*j+i] & y[4*j+i]) | ((x[4*j+i] ^ y[4*j+i]) & bc);
            end
        end
        return {gc[NG], s};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_in;
    logic             out_valid_q, out_valid_d, cout_q, cout_d;
    logic             flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_v_q, flag_v_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    assign advance  = !out_valid_q | out_ready;
    assign in_ready = advance & !rst;
    assign b_in     = sub ? ~b : b;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : stg
        localparam int UW = WIDTH - k * CHUNK;
        localparam int PW = (k + 1) * CHUNK;
        logic [UW-1:0]  sa, sb;
        logic           sc, sv;
        logic [CHUNK:0] r;
        logic [PW-1:0]  ps;
        assign r = cla(sa[CHUNK-1:0], sb[CHUNK-1:0], sc);
        if (k == 0) begin : src
            assign sa = a;
            assign sb = b_in;
            assign sc = sub;
            assign sv = in_valid & in_ready;
            assign ps = r[CHUNK-1:0];
        end else begin : src
            assign sa = stg[k-1].pr.a_q;
            assign sb = stg[k-1].pr.b_q;
            assign sc = stg[k-1].pr.c_q;
            assign sv = stg[k-1].pr.v_q;
            assign ps = {r[CHUNK-1:0], stg[k-1].pr.s_q};
        end
        if (k < STAGES - 1) begin : pr
            localparam int RW = UW - CHUNK;
            logic [RW-1:0] a_q, a_d, b_q, b_d;
            logic [PW-1:0] s_q, s_d;
            logic          c_q, c_d, v_q, v_d;
            always_comb begin
                v_d = advance ? sv : v_q;
                a_d = (advance & sv) ? sa[UW-1:CHUNK] : a_q;
                b_d = (advance & sv) ? sb[UW-1:CHUNK] : b_q;
                s_d = (advance & sv) ? ps : s_q;
                c_d = (advance & sv) ? r[CHUNK] : c_q;
            end
            always_ff @(posedge clk) begin
                if (rst) v_q <= 1'b0;
                else     v_q <= v_d;
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
                c_q <= c_d;
            end
        end else begin : fin
            logic             raw_v, ld;
            logic [WIDTH-1:0] fs;
            always_comb begin
                raw_v = (sa[UW-1] == sb[UW-1]) & (ps[WIDTH-1] != sa[UW-1]);
`ifdef PADD_SAT_EN
                fs = raw_v ? {sa[UW-1], {(WIDTH-1){~sa[UW-1]}}} : ps;
`else
                fs = ps;
`endif
                ld          = advance & sv;
                out_valid_d = advance ? sv : out_valid_q;
                sum_d       = ld ? fs : sum_q;
                cout_d      = ld ? r[CHUNK] : cout_q;
                flag_z_d    = ld ? (fs == '0) : flag_z_q;
                flag_n_d    = ld ? fs[WIDTH-1] : flag_n_q;
                flag_v_d    = ld ? raw_v : flag_v_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed vectors, backpressure and mid-run reset for the 16-bit 2-stage adder
module tb_pipelined_cla_adder;
    logic        clk, rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cout, flag_z, flag_n, flag_v;
    int          errors = 0;
    int          checks = 0;
`ifdef PADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] s;
        logic        c, z, n, v;
    } vec_t;
    vec_t tv[10];

    pipelined_cla_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int  sent, got, left;
        bit  stalled, acc;
        tv[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b0, !SAT, 1'b1};
        tv[2] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b0, SAT, 1'b1};
        tv[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[7] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, !SAT, SAT, 1'b1};
        tv[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[9] = '{16'h4000, 16'h4000, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b0, !SAT, 1'b1};
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        step;
        step;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, flag_z, flag_n, flag_v}, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = tv[i].a; b = tv[i].b; sub = tv[i].sub;
            step;
            check($sformatf("vec%0d_latency", i), out_valid, 0);
            in_valid = 1'b0;
            step;
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_sum", i), sum, tv[i].s);
            check($sformatf("vec%0d_cznv", i), {cout, flag_z, flag_n, flag_v}, {tv[i].c, tv[i].z, tv[i].n, tv[i].v});
        end
        step;
        sub = 1'b0; in_valid = 1'b1; a = 16'd1; b = 16'd1;
        sent = 0; got = 0; left = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid && !stalled) begin
                stalled = 1'b1;
                left = 3;
            end
            out_ready = (left == 0);
            #1;
            if (left > 0) begin
                check("stall_sum", sum, 16'h0002);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                left--;
            end
            if (out_valid && out_ready) begin
                check($sformatf("order%0d", got), sum, 32'(2 * (got + 1)));
                got++;
            end
            acc = in_valid && in_ready;
            step;
            if (acc) begin
                sent++;
                if (sent < 4) begin
                    a = 16'(sent + 1);
                    b = 16'(sent + 1);
                end else in_valid = 1'b0;
            end
        end
        check("bp_count", got, 4);
        for (int i = 0; i < 3; i++) begin
            check("bp_no_dup", out_valid, 0);
            step;
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0100; b = 16'h0001;
        step;
        a = 16'h0200;
        step;
        in_valid = 1'b0;
        check("pre_rst_sum", sum, 16'h0101);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        step;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_flags", {cout, flag_z, flag_n, flag_v}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step;
            check("no_stale", out_valid, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream handshake and optional signed saturation. It generalises the single-cycle 16-bit CLA to any width and splits the carry chain into registered chunks. One result per cycle in steady state. It serves the execute stage's ADD/SUB/address paths wherever the combinational carry path is too long for the target clock.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of STAGES*4.
- STAGES, 2: pipeline depth; CHUNK = WIDTH/STAGES bits resolved per stage, built from 4-bit lookahead groups.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B (B inverted, carry-in 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts a result.
- sum  output  WIDTH  result (saturated when enabled).
- cout  output  1  unsigned carry out of the MSB (raw, pre-saturation).
- flag_z  output  1  sum == 0.
- flag_n  output  1  sum[WIDTH-1].
- flag_v  output  1  signed overflow of the raw result.

## Operation
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1 (stage 0 uses sub as carry-in). Stage k then registers its partial sum, its carry, and the unconsumed upper operand bits.
- Within a stage, the carry is produced as group generate/propagate across 4-bit groups; no ripple between groups.
- Each stage holds one valid bit. advance = !out_valid | out_ready. When advance = 1, every stage shifts forward; stage 0 loads the input beat when in_valid = 1, otherwise it loads a bubble.
- in_ready = advance & !rst. A beat is accepted iff in_valid & in_ready.
- When advance = 0, all stages and outputs hold, and sum/flags stay stable while out_valid = 1.
- The final stage computes the flags:
  - flag_v = (a_msb == b'_msb) & (raw_msb != a_msb), where b' is B after inversion for sub.
  - cout = final carry.
  - flag_z and flag_n are computed on the post-saturation sum.
- Results leave in strict acceptance order; none are dropped or duplicated.
- STAGES = 1 degenerates to a single registered full-width CLA, with latency 1.

## Timing
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+STAGES, with no backpressure.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure with out_valid & !out_ready stalls the whole pipeline in the same cycle, and in_ready drops combinationally.
- Reset values, applied at the first rising edge with rst = 1: all stage valid bits 0, out_valid 0, sum 0, cout 0, flag_z 0, flag_n 0, flag_v 0.
- in_ready is 0 while rst = 1 and 1 in the first cycle after reset is released.
- Reset mid-operation discards all in-flight beats; no result from before the reset ever appears.
- Simultaneous accept and emit in one cycle is legal and is the steady state.
- Bubbles (stage valid = 0) propagate without affecting the held output data.

## Configuration
- PADD_SAT_EN defined: when flag_v = 1, sum saturates to the signed extreme in the direction of the true result.
  - Positive overflow gives 0111…1 (16-bit: 0x7FFF).
  - Negative overflow gives 100…0 (16-bit: 0x8000).
  - cout and flag_v still report raw values.
- PADD_SAT_EN undefined: sum is the raw modulo-2^WIDTH result, and no saturation logic is present.

## Test plan
All scenarios use WIDTH=16, STAGES=2, out_ready=1 unless stated.
- 0x1234 + 0x0001, sub=0 -> two edges later: sum 0x1235, z=0, n=0, v=0, cout=0.
- 0x7FFF + 0x0001:
  - PADD_SAT_EN defined -> sum 0x7FFF, v=1, n=0.
  - PADD_SAT_EN undefined -> sum 0x8000, v=1, n=1.
- 0x8000 - 0x0001 with PADD_SAT_EN defined -> sum 0x8000, v=1, cout=1. Also 0x0005 - 0x0005 -> sum 0x0000, z=1, cout=1.
- Four back-to-back beats (1+1, 2+2, 3+3, 4+4), with out_ready held low for 3 cycles after the first out_valid:
  - sum holds 0x0002 throughout the stall, and in_ready = 0 during it.
  - Outputs then emerge in order: 0x0002, 0x0004, 0x0006, 0x0008.
  - No loss and no duplicates.
- Two beats in flight, then rst=1 for 1 cycle -> out_valid=0 and all outputs 0 at the next edge. No stale result emerges afterwards, and in_ready=1 the cycle after rst falls.
- 0xFFFF + 0x0001 -> sum 0x0000, cout=1, z=1, v=0. This checks the inter-stage carry crossing the chunk boundary at bit 8.
